// File: rtl/arm_alu_pkg.sv
// Shared types and helpers for the ARM data-processing ALU.
// Flag vectors are ordered {C,N,V,Z}; the FLAG_* localparams give the bit positions.
package arm_alu_pkg;

    typedef enum logic [3:0] {
        OpAnd = 4'b0000,
        OpEor = 4'b0001,
        OpSub = 4'b0010,
        OpRsb = 4'b0011,
        OpAdd = 4'b0100,
        OpAdc = 4'b0101,
        OpSbc = 4'b0110,
        OpRsc = 4'b0111,
        OpTst = 4'b1000,
        OpTeq = 4'b1001,
        OpCmp = 4'b1010,
        OpCmn = 4'b1011,
        OpOrr = 4'b1100,
        OpMov = 4'b1101,
        OpBic = 4'b1110,
        OpMvn = 4'b1111
    } alu_op_t;

    localparam int unsigned FLAG_C = 3;
    localparam int unsigned FLAG_N = 2;
    localparam int unsigned FLAG_V = 1;
    localparam int unsigned FLAG_Z = 0;

    function automatic logic is_logical(input alu_op_t op);
        logic w_logic;
        unique case (op)
            OpAnd, OpEor, OpTst, OpTeq,
            OpOrr, OpMov, OpBic, OpMvn: w_logic = 1'b1;
            default:                    w_logic = 1'b0;
        endcase
        return w_logic;
    endfunction

endpackage

// File: rtl/arm_alu_adder.sv
// WIDTH-bit adder shared by every arithmetic opcode of arm_alu.
// cout is the carry out of the WIDTH+1-bit sum; ovf is two's-complement overflow.
module arm_alu_adder #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    logic [WIDTH:0] w_full;

    assign w_full = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, cin};
    assign sum    = w_full[WIDTH-1:0];
    assign cout   = w_full[WIDTH];
    // Operands share a sign but the result's sign differs.
    assign ovf    = (x[WIDTH-1] == y[WIDTH-1]) && (w_full[WIDTH-1] != x[WIDTH-1]);

endmodule

// File: rtl/arm_alu.sv
// ARM data-processing ALU: 16 opcodes, registered result and {C,N,V,Z} flags.
// Optional macro ALU_LOGIC_FLAGS_EN: logical ops set N and pass C/V through from CNVZI.
module arm_alu
    import arm_alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       ALUFUN,
    input  logic [3:0]       CNVZI,
    output logic [WIDTH-1:0] s,
    output logic [3:0]       CNVZO
);

    alu_op_t          w_op;
    logic [WIDTH-1:0] w_add_x;
    logic [WIDTH-1:0] w_add_y;
    logic             w_add_cin;
    logic [WIDTH-1:0] w_sum;
    logic             w_cout;
    logic             w_ovf;
    logic [WIDTH-1:0] w_result;
    logic [3:0]       w_flags;
    logic             w_cin;
    logic             w_unused_flags;

    logic [WIDTH-1:0] r_s;
    logic [3:0]       r_flags;

    assign w_op  = alu_op_t'(ALUFUN);
    assign w_cin = CNVZI[FLAG_C];
    // Only some incoming flag bits feed the default build.
    assign w_unused_flags = ^CNVZI;

    // Subtracts are expressed as x + ~y + carry so one adder serves all of them.
    always_comb begin
        w_add_x   = a;
        w_add_y   = b;
        w_add_cin = 1'b0;
        unique case (w_op)
            OpSub, OpCmp: begin
                w_add_y   = ~b;
                w_add_cin = 1'b1;
            end
            OpRsb: begin
                w_add_x   = b;
                w_add_y   = ~a;
                w_add_cin = 1'b1;
            end
            OpAdc: w_add_cin = w_cin;
            OpSbc: begin
                w_add_y   = ~b;
                w_add_cin = w_cin;
            end
            OpRsc: begin
                w_add_x   = b;
                w_add_y   = ~a;
                w_add_cin = w_cin;
            end
            default: ;
        endcase
    end

    arm_alu_adder #(
        .WIDTH (WIDTH)
    ) u_adder (
        .x    (w_add_x),
        .y    (w_add_y),
        .cin  (w_add_cin),
        .sum  (w_sum),
        .cout (w_cout),
        .ovf  (w_ovf)
    );

    always_comb begin
        w_result = w_sum;
        unique case (w_op)
            OpAnd, OpTst: w_result = a & b;
            OpEor, OpTeq: w_result = a ^ b;
            OpOrr:        w_result = a | b;
            OpMov:        w_result = b;
            OpBic:        w_result = a & ~b;
            OpMvn:        w_result = ~b;
            default:      ;
        endcase
    end

    always_comb begin
        w_flags = 4'b0000;
        if (is_logical(w_op)) begin
`ifdef ALU_LOGIC_FLAGS_EN
            w_flags[FLAG_C] = CNVZI[FLAG_C];
            w_flags[FLAG_N] = w_result[WIDTH-1];
            w_flags[FLAG_V] = CNVZI[FLAG_V];
`else
            w_flags[FLAG_C] = 1'b0;
            w_flags[FLAG_N] = 1'b0;
            w_flags[FLAG_V] = 1'b0;
`endif
        end else begin
            w_flags[FLAG_C] = w_cout;
            w_flags[FLAG_N] = w_result[WIDTH-1];
            w_flags[FLAG_V] = w_ovf;
        end
        w_flags[FLAG_Z] = ~|w_result;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s     <= '0;
            r_flags <= 4'b0000;
        end else begin
            r_s     <= w_result;
            r_flags <= w_flags;
        end
    end

    assign s     = r_s;
    assign CNVZO = r_flags;

endmodule

// File: tb/tb_arm_alu.sv
// Directed-vector bench for arm_alu at WIDTH=4 (default build, macro undefined).
module tb_arm_alu;

    localparam int unsigned WIDTH = 4;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       ALUFUN;
    logic [3:0]       CNVZI;
    logic [WIDTH-1:0] s;
    logic [3:0]       CNVZO;

    int n_total;
    int n_bad;

    arm_alu #(
        .WIDTH (WIDTH)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .a      (a),
        .b      (b),
        .ALUFUN (ALUFUN),
        .CNVZI  (CNVZI),
        .s      (s),
        .CNVZO  (CNVZO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Drive on the falling edge, sample 1 time unit after the capturing rising edge.
    task automatic run_vec(input string tag, input logic [3:0] op, input logic [3:0] va,
                           input logic [3:0] vb, input logic [3:0] flags_in,
                           input logic [3:0] exp_s, input logic [3:0] exp_f);
        @(negedge clk);
        ALUFUN = op;
        a      = va;
        b      = vb;
        CNVZI  = flags_in;
        @(posedge clk);
        #1;
        check({tag, ".s"}, {4'b0000, s}, {4'b0000, exp_s});
        check({tag, ".f"}, {4'b0000, CNVZO}, {4'b0000, exp_f});
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        rst     = 1'b1;
        a       = 4'b0101;
        b       = 4'b0011;
        ALUFUN  = 4'b0100;
        CNVZI   = 4'b1111;
        @(posedge clk);
        #1;
        check("reset.s", {4'b0000, s}, 8'h00);
        check("reset.f", {4'b0000, CNVZO}, 8'h00);
        @(negedge clk);
        rst = 1'b0;

        run_vec("and_c0",  4'b0000, 4'b1111, 4'b1010, 4'b0000, 4'b1010, 4'b0000);
        run_vec("and_c1",  4'b0000, 4'b1111, 4'b1010, 4'b1111, 4'b1010, 4'b0000);
        run_vec("and_z",   4'b0000, 4'b0101, 4'b1010, 4'b0000, 4'b0000, 4'b0001);
        run_vec("eor",     4'b0001, 4'b1111, 4'b1010, 4'b0000, 4'b0101, 4'b0000);
        run_vec("eor_z",   4'b0001, 4'b1100, 4'b1100, 4'b1111, 4'b0000, 4'b0001);
        run_vec("sub",     4'b0010, 4'b1111, 4'b1010, 4'b0000, 4'b0101, 4'b1000);
        run_vec("rsb",     4'b0011, 4'b1111, 4'b1010, 4'b0000, 4'b1011, 4'b0100);
        run_vec("add",     4'b0100, 4'b0011, 4'b0001, 4'b0000, 4'b0100, 4'b0000);
        run_vec("add_v",   4'b0100, 4'b0111, 4'b0001, 4'b0000, 4'b1000, 4'b0110);
        run_vec("adc",     4'b0101, 4'b1111, 4'b1010, 4'b1000, 4'b1010, 4'b1100);
        run_vec("sbc",     4'b0110, 4'b0101, 4'b0011, 4'b0000, 4'b0001, 4'b1000);
        run_vec("sbc_v",   4'b0110, 4'b1000, 4'b0001, 4'b1000, 4'b0111, 4'b1010);
        run_vec("rsc",     4'b0111, 4'b0011, 4'b0101, 4'b1000, 4'b0010, 4'b1000);
        run_vec("tst",     4'b1000, 4'b1000, 4'b0111, 4'b0000, 4'b0000, 4'b0001);
        run_vec("teq",     4'b1001, 4'b1001, 4'b0110, 4'b1111, 4'b1111, 4'b0000);
        run_vec("cmp",     4'b1010, 4'b0101, 4'b0101, 4'b0000, 4'b0000, 4'b1001);
        run_vec("cmn",     4'b1011, 4'b1000, 4'b1000, 4'b0000, 4'b0000, 4'b1011);
        run_vec("orr",     4'b1100, 4'b0101, 4'b0010, 4'b0000, 4'b0111, 4'b0000);
        run_vec("mov",     4'b1101, 4'b1111, 4'b0000, 4'b1111, 4'b0000, 4'b0001);
        run_vec("bic",     4'b1110, 4'b1111, 4'b1010, 4'b0000, 4'b0101, 4'b0000);
        run_vec("mvn",     4'b1111, 4'b0000, 4'b0000, 4'b1111, 4'b1111, 4'b0000);

        // Reset while an ADD with a nonzero result is presented, then release.
        run_vec("pre_rst", 4'b0100, 4'b0011, 4'b0001, 4'b0000, 4'b0100, 4'b0000);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst.s", {4'b0000, s}, 8'h00);
        check("mid_rst.f", {4'b0000, CNVZO}, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst.s", {4'b0000, s}, {4'b0000, 4'b0100});
        check("post_rst.f", {4'b0000, CNVZO}, 8'h00);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
